// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the cpu run/halt controller: controller states, host
// command opcodes and latched halt causes.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd2,
        ST_RUN_N = 3'd3,
        ST_ERROR = 3'd4
    } RunState;

    typedef enum logic [1:0] {
        OP_RUN     = 2'd0,
        OP_RUN_N   = 2'd1,
        OP_HALT    = 2'd2,
        OP_RESTART = 2'd3
    } RunOp;

    typedef enum logic [2:0] {
        HC_NONE  = 3'd0,
        HC_HOST  = 3'd1,
        HC_STOP  = 3'd2,
        HC_ERROR = 3'd3,
        HC_COUNT = 3'd4
    } HaltCause;

    // A reset hold shorter than one cycle would never assert cpu_reset.
    function automatic int hold_cycles(input int hold);
        return (hold < 1) ? 1 : hold;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt controller: drives the cpu's synchronous reset and clock-enable,
// handles free-run, run-N and host halt, and records why the cpu stopped.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_W    = 32,
    parameter int COUNT_W    = 16,
    parameter int ERR_W      = 2,
    parameter int RESET_HOLD = 2,
    parameter int AUTO_RUN   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic               cmd_err,
    input  logic               cpu_stop,
    input  logic [ERR_W-1:0]   cpu_error,
    output logic               cpu_reset,
    output logic               cpu_en,
    output logic [2:0]         state,
    output logic [2:0]         halt_cause,
    output logic [ERR_W-1:0]   err_latched,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int HOLD_N = hold_cycles(RESET_HOLD);
    localparam int HOLD_W = $clog2(HOLD_N + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);

    RunState            cur_state;
    RunState            nxt_state;
    HaltCause           cause_q;
    HaltCause           cause_d;
    RunOp               op;
    logic [ERR_W-1:0]   err_q;
    logic [ERR_W-1:0]   err_d;
    logic [COUNT_W-1:0] rem_q;
    logic [COUNT_W-1:0] rem_d;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;
    logic               cmd_err_d;
    logic               do_restart;
    logic               accept;
    logic               running;

    assign op          = RunOp'(cmd_op);
    assign state       = cur_state;
    assign halt_cause  = cause_q;
    assign err_latched = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= ST_HOLD;
            cause_q   <= HC_NONE;
            err_q     <= '0;
            rem_q     <= '0;
            hold_q    <= '0;
            cmd_err   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cause_q   <= cause_d;
            err_q     <= err_d;
            rem_q     <= rem_d;
            hold_q    <= hold_d;
            cmd_err   <= cmd_err_d;
        end
    end

    // Stop and error outrank any command; a command accepted in such a cycle
    // is consumed silently. Within a running cycle the command is applied
    // after budget exhaustion so that HALT wins over COUNT.
    always_comb begin
        nxt_state  = cur_state;
        cause_d    = cause_q;
        err_d      = err_q;
        rem_d      = rem_q;
        hold_d     = hold_q;
        cmd_err_d  = 1'b0;
        do_restart = 1'b0;
        case (cur_state)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d    = '0;
                    nxt_state = (AUTO_RUN != 0) ? ST_RUN : ST_IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_RUN: begin
                            nxt_state = ST_RUN;
                            cause_d   = HC_NONE;
                        end
                        OP_RUN_N: begin
                            if (cmd_count != '0) begin
                                rem_d     = cmd_count;
                                nxt_state = ST_RUN_N;
                                cause_d   = HC_NONE;
                            end else begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        OP_HALT:    cause_d    = HC_HOST;
                        OP_RESTART: do_restart = 1'b1;
                        default:    cmd_err_d  = 1'b1;
                    endcase
                end
            end
            ST_RUN, ST_RUN_N: begin
                if (cpu_error != '0) begin
                    nxt_state = ST_ERROR;
                    cause_d   = HC_ERROR;
                    err_d     = cpu_error;
                end else if (cpu_stop) begin
                    nxt_state = ST_IDLE;
                    cause_d   = HC_STOP;
                end else begin
                    if ((cur_state == ST_RUN_N) && cpu_en) begin
                        if (rem_q == COUNT_W'(1)) begin
                            rem_d     = '0;
                            nxt_state = ST_IDLE;
                            cause_d   = HC_COUNT;
                        end else begin
                            rem_d = rem_q - COUNT_W'(1);
                        end
                    end
                    if (accept) begin
                        case (op)
                            OP_RUN: begin
                                nxt_state = ST_RUN;
                                cause_d   = HC_NONE;
                            end
                            OP_RUN_N: begin
                                if (cmd_count != '0) begin
                                    rem_d     = cmd_count;
                                    nxt_state = ST_RUN_N;
                                    cause_d   = HC_NONE;
                                end else begin
                                    cmd_err_d = 1'b1;
                                end
                            end
                            OP_HALT: begin
                                nxt_state = ST_IDLE;
                                cause_d   = HC_HOST;
                            end
                            OP_RESTART: do_restart = 1'b1;
                            default:    cmd_err_d  = 1'b1;
                        endcase
                    end
                end
            end
            ST_ERROR: begin
                if (accept) begin
                    if (op == OP_RESTART) begin
                        do_restart = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            default: nxt_state = ST_HOLD;
        endcase
        if (do_restart) begin
            nxt_state = ST_HOLD;
            hold_d    = '0;
            cause_d   = HC_NONE;
            err_d     = '0;
            rem_d     = '0;
        end
    end

    // cpu_en must react to stop/error within the same cycle so the cpu never
    // advances on a cycle that reports them.
    always_comb begin
        running   = (cur_state == ST_RUN) || (cur_state == ST_RUN_N);
        cpu_en    = running && !cpu_stop && (cpu_error == '0);
        cpu_reset = (cur_state == ST_HOLD);
        cmd_ready = (cur_state != ST_HOLD);
        accept    = cmd_valid && cmd_ready;
    end

    sat_counter #(
        .W(CYCLE_W)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clear (do_restart),
        .inc   (cpu_en),
        .value (cycle_count)
    );

endmodule
